// File: rtl/pipe_scheduler_pkg.sv
// Shared types and helpers for the pipe scheduler: state encoding, field widths
// and the random-number-to-gap mapping.
package pipe_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  localparam int X_W     = 12;
  localparam int GAP_W   = 10;
  localparam int RND_W   = 10;
  localparam int SCORE_W = 10;
  localparam logic [SCORE_W-1:0] SCORE_MAX = 10'd999;

  // Scale a 10-bit random value into gap_min..gap_min+gap_range-1 with an exact 19-bit product.
  function automatic logic [GAP_W-1:0] map_gap(input logic [RND_W-1:0] rnd,
                                               input int gap_min,
                                               input int gap_range);
    logic [18:0] prod;
    prod = {9'd0, rnd} * 19'(gap_range);
    return GAP_W'(gap_min) + GAP_W'(prod >> RND_W);
  endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipe slot: holds valid/x/gap_y, scrolls on step, and flags its own
// retirement and bird-column crossing.
module pipe_slot
  import pipe_scheduler_pkg::*;
#(
  parameter int SCREEN_W = 640,
  parameter int PIPE_W   = 52,
  parameter int SPEED    = 2,
  parameter int BIRD_X   = 160
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    step,
  input  logic                    load,
  input  logic [GAP_W-1:0]        load_gap,
  output logic                    valid,
  output logic signed [X_W-1:0]   x,
  output logic [GAP_W-1:0]        gap_y,
  output logic                    scored
);

  localparam int EW = X_W + 1;
  localparam logic signed [EW-1:0] PW   = EW'(PIPE_W);
  localparam logic signed [EW-1:0] SPD  = EW'(SPEED);
  localparam logic signed [EW-1:0] BX   = EW'(BIRD_X);
  localparam logic signed [EW-1:0] ZERO = '0;

  logic signed [EW-1:0] x_ext;
  logic signed [EW-1:0] x_new;
  logic                 move;
  logic                 retire;

  // One extra bit of headroom so right-edge sums never wrap.
  always_comb begin
    x_ext  = {x[X_W-1], x};
    x_new  = x_ext - SPD;
    move   = valid && step;
    retire = move && ((x_new + PW) <= ZERO);
    scored = move && ((x_ext + PW) > BX) && ((x_new + PW) <= BX);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      x     <= '0;
      gap_y <= '0;
    end else if (clear) begin
      valid <= 1'b0;
      x     <= '0;
      gap_y <= '0;
    end else if (load) begin
      valid <= 1'b1;
      x     <= X_W'(SCREEN_W);
      gap_y <= load_gap;
    end else if (move) begin
      x <= x_new[X_W-1:0];
      if (retire) valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pipe_scheduler.sv
// Pipe pool manager: game FSM, spawn distance counter, free-slot picker,
// gap mapping and score counter around NUM_PIPES pipe_slot instances.
module pipe_scheduler
  import pipe_scheduler_pkg::*;
#(
  parameter int NUM_PIPES    = 4,
  parameter int SCREEN_W     = 640,
  parameter int PIPE_W       = 52,
  parameter int PIPE_SPACING = 200,
  parameter int SPEED        = 2,
  parameter int BIRD_X       = 160,
  parameter int GAP_MIN      = 40,
  parameter int GAP_RANGE    = 281,
  localparam int IDX_W       = $clog2(NUM_PIPES)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_tick,
  input  logic                  start,
  input  logic                  crash,
  input  logic [RND_W-1:0]      rnd_num,
  output logic                  rnd_req,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic                  rd_valid,
  output logic signed [X_W-1:0] rd_x,
  output logic [GAP_W-1:0]      rd_gap_y,
  output logic                  score_pulse,
  output logic [SCORE_W-1:0]    score,
  output logic [1:0]            state,
  output logic                  spawn_overflow
);

  localparam int DIST_W = $clog2(PIPE_SPACING + SPEED + 1);

  state_t                 state_q, state_d;
  logic                   run, restart, advance, spawn_due, found;
  logic [DIST_W-1:0]      dist_q, dist_sum;
  logic [IDX_W-1:0]       free_idx;
  logic [GAP_W-1:0]       gap_new;
  logic [NUM_PIPES-1:0]   valid_vec, scored_vec, load_vec;
  logic signed [X_W-1:0]  x_arr   [NUM_PIPES];
  logic [GAP_W-1:0]       gap_arr [NUM_PIPES];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start) state_d = ST_RUN;
      ST_RUN:  if (crash) state_d = ST_HALT;
      ST_HALT: if (start) state_d = ST_RUN;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    run     = (state_q == ST_RUN);
    restart = start && (state_q != ST_RUN);
  end

  assign state = state_q;

  // rnd_req is combinational: high in the cycle whose clock edge captures rnd_num
  // into a slot, so the generator may advance on that same edge.
  always_comb begin
    advance   = run && frame_tick && !crash;
    dist_sum  = dist_q + DIST_W'(SPEED);
    spawn_due = advance && (dist_sum >= DIST_W'(PIPE_SPACING));
    gap_new   = map_gap(rnd_num, GAP_MIN, GAP_RANGE);
    found     = 1'b0;
    free_idx  = '0;
    for (int i = NUM_PIPES - 1; i >= 0; i--) begin
      if (!valid_vec[i]) begin
        found    = 1'b1;
        free_idx = IDX_W'(i);
      end
    end
    rnd_req = spawn_due && found;
  end

  for (genvar g = 0; g < NUM_PIPES; g++) begin : g_slot
    assign load_vec[g] = rnd_req && (free_idx == IDX_W'(g));
    pipe_slot #(
      .SCREEN_W (SCREEN_W),
      .PIPE_W   (PIPE_W),
      .SPEED    (SPEED),
      .BIRD_X   (BIRD_X)
    ) u_slot (
      .clk      (clk),
      .rst_n    (rst_n),
      .clear    (restart),
      .step     (advance),
      .load     (load_vec[g]),
      .load_gap (gap_new),
      .valid    (valid_vec[g]),
      .x        (x_arr[g]),
      .gap_y    (gap_arr[g]),
      .scored   (scored_vec[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dist_q         <= '0;
      score          <= '0;
      score_pulse    <= 1'b0;
      spawn_overflow <= 1'b0;
    end else begin
      score_pulse <= 1'b0;
      if (restart) begin
        dist_q         <= DIST_W'(PIPE_SPACING);
        score          <= '0;
        spawn_overflow <= 1'b0;
      end else if (advance) begin
        dist_q <= spawn_due ? '0 : dist_sum;
        if (spawn_due && !found) spawn_overflow <= 1'b1;
        if (|scored_vec) begin
          score_pulse <= 1'b1;
          if (score != SCORE_MAX) score <= score + 1'b1;
        end
      end
    end
  end

  assign rd_valid = valid_vec[rd_idx];
  assign rd_x     = x_arr[rd_idx];
  assign rd_gap_y = gap_arr[rd_idx];

endmodule

// File: tb/tb_pipe_scheduler.sv
// Randomised bench for pipe_scheduler: two instances (default spacing and spacing 20)
// compared every cycle against a behavioural model, with a score-event scoreboard.
`timescale 1ns/1ps
module tb_pipe_scheduler;

  logic        clk = 1'b0;
  logic        rst_n, frame_tick, start, crash;
  logic [9:0]  rnd_num;
  logic [1:0]  rd_idx, rd_idx_b;

  logic        rnd_req_a, rd_valid_a, score_pulse_a, ovf_a;
  logic signed [11:0] rd_x_a;
  logic [9:0]  rd_gap_y_a, score_a;
  logic [1:0]  state_a;
  logic        rnd_req_b, rd_valid_b, score_pulse_b, ovf_b;
  logic signed [11:0] rd_x_b;
  logic [9:0]  rd_gap_y_b, score_b;
  logic [1:0]  state_b;

  int checks = 0;
  int errors = 0;
  logic [9:0] exp_q[$];

  // Model state, index 0 = default instance, 1 = spacing-20 instance.
  int spacing[2] = '{200, 20};
  int m_st[2], m_dist[2], m_score[2];
  bit m_ovf[2], m_sp[2];
  bit m_v[2][4];
  int m_x[2][4], m_gap[2][4];

  always #5 clk = ~clk;

  pipe_scheduler dut_a (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .crash(crash),
    .rnd_num(rnd_num), .rnd_req(rnd_req_a), .rd_idx(rd_idx), .rd_valid(rd_valid_a),
    .rd_x(rd_x_a), .rd_gap_y(rd_gap_y_a), .score_pulse(score_pulse_a), .score(score_a),
    .state(state_a), .spawn_overflow(ovf_a)
  );

  pipe_scheduler #(.PIPE_SPACING(20)) dut_b (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start(start), .crash(crash),
    .rnd_num(rnd_num), .rnd_req(rnd_req_b), .rd_idx(rd_idx_b), .rd_valid(rd_valid_b),
    .rd_x(rd_x_b), .rd_gap_y(rd_gap_y_b), .score_pulse(score_pulse_b), .score(score_b),
    .state(state_b), .spawn_overflow(ovf_b)
  );

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset(input int m);
    m_st[m] = 0; m_dist[m] = 0; m_score[m] = 0; m_ovf[m] = 0; m_sp[m] = 0;
    for (int i = 0; i < 4; i++) begin
      m_v[m][i] = 0; m_x[m][i] = 0; m_gap[m][i] = 0;
    end
  endtask

  task automatic model_restart(input int m);
    for (int i = 0; i < 4; i++) m_v[m][i] = 0;
    m_score[m] = 0; m_ovf[m] = 0; m_st[m] = 1; m_dist[m] = spacing[m];
  endtask

  function automatic bit has_free(input int m);
    for (int i = 0; i < 4; i++) if (!m_v[m][i]) return 1;
    return 0;
  endfunction

  function automatic bit spawn_now(input int m);
    return rst_n && m_st[m] == 1 && frame_tick && !crash &&
           (m_dist[m] + 2 >= spacing[m]) && has_free(m);
  endfunction

  // Applies the rules of one clock edge with the inputs present at that edge.
  task automatic model_step(input int m);
    int f, xn;
    bit sc;
    m_sp[m] = 0;
    if (!rst_n) begin
      model_reset(m);
      return;
    end
    case (m_st[m])
      0, 2: if (start) model_restart(m);
      1: begin
        if (crash) m_st[m] = 2;
        else if (frame_tick) begin
          f = -1;
          for (int i = 0; i < 4; i++) if (!m_v[m][i] && f < 0) f = i;
          sc = 0;
          for (int i = 0; i < 4; i++) begin
            if (m_v[m][i]) begin
              xn = m_x[m][i] - 2;
              if (m_x[m][i] + 52 > 160 && xn + 52 <= 160) sc = 1;
              m_x[m][i] = xn;
              if (xn + 52 <= 0) m_v[m][i] = 0;
            end
          end
          if (sc) begin
            m_score[m] = (m_score[m] < 999) ? m_score[m] + 1 : 999;
            m_sp[m] = 1;
            if (m == 0) exp_q.push_back(10'(m_score[m]));
          end
          m_dist[m] += 2;
          if (m_dist[m] >= spacing[m]) begin
            m_dist[m] = 0;
            if (f >= 0) begin
              m_v[m][f] = 1; m_x[m][f] = 640; m_gap[m][f] = 40 + (int'(rnd_num) * 281) / 1024;
            end else m_ovf[m] = 1;
          end
        end
      end
      default: ;
    endcase
  endtask

  task automatic chk_inst(input int m, input string p, input logic rr, input logic sp,
                          input logic [9:0] sc, input logic [1:0] st, input logic ov,
                          input logic rv, input logic signed [11:0] rx,
                          input logic [9:0] rg, input logic [1:0] ri);
    chk({p, "state"}, int'(st), m_st[m]);
    chk({p, "score"}, int'(sc), m_score[m]);
    chk({p, "overflow"}, int'(ov), int'(m_ovf[m]));
    chk({p, "score_pulse"}, int'(sp), int'(m_sp[m]));
    chk({p, "rnd_req"}, int'(rr), int'(spawn_now(m)));
    chk({p, "rd_valid"}, int'(rv), int'(m_v[m][ri]));
    if (m_v[m][ri]) begin
      chk({p, "rd_x"}, int'(rx), m_x[m][ri]);
      chk({p, "rd_gap_y"}, int'(rg), m_gap[m][ri]);
    end
  endtask

  // Monitor: per-cycle model comparison plus scoreboard pop on every score pulse.
  always @(negedge clk) begin
    chk_inst(0, "a_", rnd_req_a, score_pulse_a, score_a, state_a, ovf_a,
             rd_valid_a, rd_x_a, rd_gap_y_a, rd_idx);
    chk_inst(1, "b_", rnd_req_b, score_pulse_b, score_b, state_b, ovf_b,
             rd_valid_b, rd_x_b, rd_gap_y_b, rd_idx_b);
    if (score_pulse_a) begin
      if (exp_q.size() == 0) chk("a_unexpected_score_pulse", 1, 0);
      else chk("a_score_event", int'(score_a), int'(exp_q.pop_front()));
    end
  end

  function automatic logic [9:0] rand_rnd();
    int r;
    r = $urandom_range(0, 7);
    if (r == 0) return 10'd0;
    if (r == 1) return 10'd1023;
    return 10'($urandom_range(0, 1023));
  endfunction

  // Drive one cycle of inputs, then advance the model over the following edge.
  task automatic cyc(input bit t, input bit s, input bit c, input logic [9:0] r);
    frame_tick = t; start = s; crash = c; rnd_num = r;
    rd_idx   = 2'($urandom_range(0, 3));
    rd_idx_b = 2'($urandom_range(0, 3));
    @(posedge clk);
    model_step(0);
    model_step(1);
    #2;
  endtask

  task automatic async_reset();
    #1 rst_n = 1'b0;
    #1;
    chk("async_state", int'(state_a), 0);
    chk("async_score", int'(score_a), 0);
    chk("async_rd_valid", int'(rd_valid_a), 0);
    chk("async_overflow_b", int'(ovf_b), 0);
    model_reset(0);
    model_reset(1);
    exp_q.delete();
    frame_tick = 0; start = 0; crash = 0;
    @(posedge clk);
    #2;
    cyc(0, 0, 0, 10'd0);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; frame_tick = 0; start = 0; crash = 0; rnd_num = '0;
    rd_idx = '0; rd_idx_b = '0;
    model_reset(0);
    model_reset(1);
    repeat (3) cyc(0, 0, 0, 10'd0);
    rst_n = 1'b1;
    cyc(0, 1, 0, 10'd0);
    cyc(1, 0, 0, 10'd0);
    repeat (1200) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 99) == 0, 0, rand_rnd());
    cyc(1, 0, 1, rand_rnd());
    repeat (30) cyc($urandom_range(0, 1) == 1, 0, $urandom_range(0, 1) == 1, rand_rnd());
    cyc(0, 1, 0, rand_rnd());
    repeat (600) cyc($urandom_range(0, 3) != 0, $urandom_range(0, 49) == 0,
                     $urandom_range(0, 299) == 0, rand_rnd());
    async_reset();
    cyc(0, 1, 0, 10'd0);
    repeat (200) cyc($urandom_range(0, 3) != 0, 0, 0, rand_rnd());
    frame_tick = 0; start = 0; crash = 0;
    @(negedge clk);
    #1;
    chk("a_score_events_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
